md_ctrl: RTL and testbench

Sequencing and hazard controller for the HI/LO multiply/divide unit in the E stage of the pipeline. It decides when a mult/multu/div/divu or mthi/mtlo instruction may be sent to the unit, and models the unit's busy window with its own latency counter. It stalls the D stage when an instruction that touches HI/LO collides with an operation still in flight. It also supports cancelling an in-flight operation on exception or interrupt.

---
 rtl/md_ctrl_pkg.sv | 31 +++
 rtl/md_busy_cnt.sv | 34 +++
 rtl/md_ctrl.sv | 116 +++++++++++
 tb/tb_md_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared HI/LO op encodings, controller state type and op-class helpers
// for the multiply/divide sequencing controller.
package md_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Loadable 4-bit down-counter that tracks the remaining busy cycles of the
// multiply/divide unit; zero flags the result commit cycle.
module md_busy_cnt
  import md_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Clear wins over load, load over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencing and hazard controller for the E stage:
// launches ops, models the unit busy window, stalls D on HI/LO collisions.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op_D,
  input  logic [3:0] op_E,
  input  logic       flush_E,
  input  logic       cancel,
  output logic       md_start,
  output logic [3:0] md_sel,
  output logic       hi_we,
  output logic       lo_we,
  output logic       busy,
  output logic       done,
  output logic       stall_D,
  output logic       err
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  md_state_e        state_r;
  logic             busy_r;
  logic             err_r;

  logic             start_ok_s;
  logic             md_start_s;
  logic             hi_we_s;
  logic             lo_we_s;
  logic             viol_s;
  logic             done_s;
  logic             stall_s;
  logic             cnt_zero_s;
  logic [3:0]       sel_s;
  logic [CNT_W-1:0] load_val_s;

  // Launch, write-enable, violation and stall decode; every term is gated by
  // reset so outputs read as zero while reset is held.
  always_comb begin
    start_ok_s = reset && !busy_r && !flush_E;
    md_start_s = start_ok_s && is_muldiv(op_E);
    hi_we_s    = start_ok_s && (op_E == MD_MTHI);
    lo_we_s    = start_ok_s && (op_E == MD_MTLO);
    viol_s     = reset && busy_r && !flush_E && (op_E != MD_NONE);
    done_s     = reset && busy_r && cnt_zero_s && !cancel;
    stall_s    = reset && (op_D != MD_NONE) && (md_start_s || busy_r) && !(busy_r && done_s);
    if (md_start_s || hi_we_s || lo_we_s) begin
      sel_s = op_E;
    end else begin
      sel_s = MD_NONE;
    end
    if (is_div(op_E)) begin
      load_val_s = DIV_LOAD;
    end else begin
      load_val_s = MULT_LOAD;
    end
  end

  md_busy_cnt u_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (busy_r && cancel),
    .load     (md_start_s),
    .load_val (load_val_s),
    .dec      (busy_r),
    .zero     (cnt_zero_s)
  );

  // Operation state machine with registered busy and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (viol_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (md_start_s) begin
            state_r <= is_div(op_E) ? ST_DIV : ST_MUL;
            busy_r  <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          // Cancel and the final count cycle both drop straight back to idle.
          if (cancel || cnt_zero_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign md_start = md_start_s;
  assign md_sel   = sel_s;
  assign hi_we    = hi_we_s;
  assign lo_we    = lo_we_s;
  assign busy     = busy_r;
  assign done     = done_s;
  assign stall_D  = stall_s;
  assign err      = reset && (err_r || viol_s);

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: per-cycle vector table fed through a
// scoreboard queue, plus hand-written latency measurements.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int   ML = 5;
  localparam int   DL = 10;
  localparam logic F  = 1'b0;
  localparam logic T  = 1'b1;

  typedef struct {
    logic       rst;
    logic [3:0] op_d;
    logic [3:0] op_e;
    logic       fl;
    logic       ca;
    logic       st;
    logic [3:0] sel;
    logic       hi;
    logic       lo;
    logic       bz;
    logic       dn;
    logic       stl;
    logic       er;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] op_D = MD_NONE;
  logic [3:0] op_E = MD_NONE;
  logic       flush_E = 1'b0;
  logic       cancel = 1'b0;
  logic       md_start, hi_we, lo_we, busy, done, stall_D, err;
  logic [3:0] md_sel;

  int errors = 0;
  int checks = 0;
  int vec_no = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .op_D(op_D), .op_E(op_E), .flush_E(flush_E),
    .cancel(cancel), .md_start(md_start), .md_sel(md_sel), .hi_we(hi_we),
    .lo_we(lo_we), .busy(busy), .done(done), .stall_D(stall_D), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void add(logic rst, logic [3:0] od, logic [3:0] oe, logic fl, logic ca,
                              logic st, logic [3:0] sel, logic hi, logic lo, logic bz,
                              logic dn, logic stl, logic er);
    vec_t v;
    v.rst = rst; v.op_d = od; v.op_e = oe; v.fl = fl; v.ca = ca;
    v.st = st; v.sel = sel; v.hi = hi; v.lo = lo; v.bz = bz; v.dn = dn; v.stl = stl; v.er = er;
    vecs.push_back(v);
  endfunction

  function automatic void add_idle(logic [3:0] od, logic er);
    add(T, od, MD_NONE, F, F, F, MD_NONE, F, F, F, F, F, er);
  endfunction

  function automatic void add_busy(logic [3:0] od, logic er);
    add(T, od, MD_NONE, F, F, F, MD_NONE, F, F, T, F, (od != MD_NONE), er);
  endfunction

  function automatic void add_done(logic [3:0] od, logic er);
    add(T, od, MD_NONE, F, F, F, MD_NONE, F, F, T, T, F, er);
  endfunction

  function automatic void add_start(logic [3:0] od, logic [3:0] oe, logic er);
    add(T, od, oe, F, F, T, oe, F, F, F, F, (od != MD_NONE), er);
  endfunction

  // Scoreboard: compare each queued expectation on the falling edge.
  always @(negedge clk) begin
    vec_t e;
    logic [10:0] exp_b, act_b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_b = {e.st, e.sel, e.hi, e.lo, e.bz, e.dn, e.stl, e.er};
      act_b = {md_start, md_sel, hi_we, lo_we, busy, done, stall_D, err};
      checks++;
      if (act_b !== exp_b) begin
        errors++;
        $display("FAIL vec%0d: got start,sel,hi,lo,busy,done,stall,err=%b,%0d,%b,%b,%b,%b,%b,%b required %b,%0d,%b,%b,%b,%b,%b,%b",
                 vec_no, md_start, md_sel, hi_we, lo_we, busy, done, stall_D, err,
                 e.st, e.sel, e.hi, e.lo, e.bz, e.dn, e.stl, e.er);
      end
      vec_no++;
    end
  end

  task automatic measure(input logic [3:0] op, input int exp_lat, input string name);
    int lat;
    logic got;
    lat = 0;
    got = 1'b0;
    @(posedge clk); #1;
    op_D = MD_NONE; op_E = op; flush_E = 1'b0; cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (md_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: got %b required 1", name, md_start);
    end
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      op_E = MD_NONE;
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        lat = i;
      end
    end
    checks++;
    if (!got || lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d (seen=%b) required %0d", name, lat, got, exp_lat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: got busy=%b required 0", name, busy);
    end
  endtask

  initial begin
    // Reset held: outputs forced low regardless of inputs.
    add(F, MD_MFLO, MD_MULT, F, F, F, MD_NONE, F, F, F, F, F, F);
    add(F, MD_MFLO, MD_MTHI, F, F, F, MD_NONE, F, F, F, F, F, F);
    // Mult then mflo held in D.
    add_start(MD_MFLO, MD_MULT, F);
    for (int i = 1; i < ML; i++) add_busy(MD_MFLO, F);
    add(T, MD_MFLO, MD_NONE, F, F, F, MD_NONE, F, F, T, T, F, F);
    add_idle(MD_NONE, F);
    add(T, MD_NONE, MD_MFLO, F, F, F, MD_NONE, F, F, F, F, F, F);
    // Div flushed, then issued.
    add(T, MD_NONE, MD_DIV, T, F, F, MD_NONE, F, F, F, F, F, F);
    add_idle(MD_NONE, F);
    add_start(MD_NONE, MD_DIV, F);
    for (int i = 1; i < DL; i++) add_busy(MD_NONE, F);
    add_done(MD_NONE, F);
    add_idle(MD_NONE, F);
    // Divu cancelled in cycle 4.
    add_start(MD_NONE, MD_DIVU, F);
    for (int i = 1; i < 4; i++) add_busy(MD_NONE, F);
    add(T, MD_NONE, MD_NONE, F, T, F, MD_NONE, F, F, T, F, F, F);
    for (int i = 5; i <= DL + 1; i++) add_idle(MD_NONE, F);
    // Cancel exactly in the done cycle.
    add_start(MD_MFLO, MD_MULT, F);
    for (int i = 1; i < ML; i++) add_busy(MD_MFLO, F);
    add(T, MD_MFLO, MD_NONE, F, T, F, MD_NONE, F, F, T, F, T, F);
    add_idle(MD_NONE, F);
    add_idle(MD_NONE, F);
    // mthi/mtlo while idle, and flushed mthi.
    add(T, MD_NONE, MD_MTHI, F, F, F, MD_MTHI, T, F, F, F, F, F);
    add(T, MD_NONE, MD_MTLO, F, F, F, MD_MTLO, F, T, F, F, F, F);
    add(T, MD_NONE, MD_MTHI, T, F, F, MD_NONE, F, F, F, F, F, F);
    // mthi during a mult: ignored, err sets and sticks.
    add_start(MD_NONE, MD_MULT, F);
    add(T, MD_NONE, MD_MTHI, F, F, F, MD_NONE, F, F, T, F, F, T);
    for (int i = 2; i < ML; i++) add_busy(MD_NONE, T);
    add_done(MD_NONE, T);
    add_idle(MD_NONE, T);
    add(T, MD_NONE, MD_MTHI, F, F, F, MD_MTHI, T, F, F, F, F, T);
    // Back-to-back mult then multu in the cycle after done.
    add_start(MD_NONE, MD_MULT, T);
    for (int i = 1; i < ML; i++) add_busy(MD_NONE, T);
    add_done(MD_NONE, T);
    add_start(MD_NONE, MD_MULTU, T);
    for (int i = 1; i < ML; i++) add_busy(MD_NONE, T);
    add_done(MD_NONE, T);
    add_idle(MD_NONE, T);
    // Async reset pulse mid-div: immediate idle, err cleared, no done later.
    add_start(MD_MFLO, MD_DIV, T);
    for (int i = 1; i < 4; i++) add_busy(MD_MFLO, T);
    add(F, MD_MFLO, MD_NONE, F, F, F, MD_NONE, F, F, F, F, F, F);
    for (int i = 0; i < DL + 1; i++) add_idle(MD_MFLO, F);
    add_idle(MD_NONE, F);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      reset   = vecs[i].rst;
      op_D    = vecs[i].op_d;
      op_E    = vecs[i].op_e;
      flush_E = vecs[i].fl;
      cancel  = vecs[i].ca;
      exp_q.push_back(vecs[i]);
    end
    @(negedge clk); #1;

    measure(MD_MULT, ML, "mult");
    measure(MD_DIVU, DL, "divu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
